// File: rtl/multiword_add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_add_seq_pkg
//  Description : Shared constants and FSM encodings for the sequential
//                multi-word adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package multiword_add_seq_pkg;

    // Width of one operand word handled per adder pass
    localparam int c_WORD_W = 32;

    // FSM state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_ADD  = 2'd1;
    localparam state_t c_ST_HOLD = 2'd2;

endpackage : multiword_add_seq_pkg
`default_nettype wire

// File: rtl/multiword_add_seq_lf32.sv
`default_nettype none
// ============================================================================
//  Module      : LadnerFischer32
//  Description : 32-bit combinational adder built on a Ladner-Fischer
//                parallel-prefix carry network.
//  Revision    : 1.0 - initial release
// ============================================================================
module LadnerFischer32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [31:0] w_hp;   // half-sum propagate, kept for the final XOR
    logic [31:0] w_g;    // group generate, prefix result after the loop
    logic [31:0] w_p;    // group propagate
    logic [31:0] w_gn;
    logic [31:0] w_pn;

    // Prefix tree: at level lvl each bit in the upper half of a 2^(lvl+1)
    // block merges with the top bit of the lower half; cin folds into bit 0.
    always_comb begin
        w_hp = x ^ y;
        w_g  = x & y;
        w_p  = w_hp;
        w_g[0] = w_g[0] | (w_p[0] & cin);
        w_gn = w_g;
        w_pn = w_p;
        for (int lvl = 0; lvl < 5; lvl++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = 0; i < 32; i++) begin
                if (((i >> lvl) & 1) == 1) begin
                    w_gn[5'(i)] = w_g[5'(i)] |
                                  (w_p[5'(i)] & w_g[5'(((i >> lvl) << lvl) - 1)]);
                    w_pn[5'(i)] = w_p[5'(i)] & w_p[5'(((i >> lvl) << lvl) - 1)];
                end
            end
            w_g = w_gn;
            w_p = w_pn;
        end
    end

    // Carry into bit i is the prefix generate of bits i-1..0 (cin for bit 0)
    assign s    = w_hp ^ {w_g[30:0], cin};
    assign cout = w_g[31];

endmodule : LadnerFischer32
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_add_seq
//  Description : Adds two NWORDS x 32-bit operands plus carry-in, one word
//                per cycle, through a single time-shared 32-bit adder.
//                Result is held with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [c_WORD_W*NWORDS-1:0]   x,
    input  logic [c_WORD_W*NWORDS-1:0]   y,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [c_WORD_W*NWORDS-1:0]   s,
    output logic                         cout
);

    localparam int c_IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_cin;
    logic                  r_carry;
    logic                  r_cout;

    logic [c_WORD_W-1:0]   w_xa [NWORDS];
    logic [c_WORD_W-1:0]   w_ya [NWORDS];
    logic [c_WORD_W-1:0]   w_add_x;
    logic [c_WORD_W-1:0]   w_add_y;
    logic [c_WORD_W-1:0]   w_add_s;
    logic                  w_add_cin;
    logic                  w_add_cout;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_adding;

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_adding  = (r_state == c_ST_ADD);
    assign w_last    = (r_idx == c_IDX_W'(NWORDS - 1));

    // Word-select mux feeding the shared adder
    assign w_add_x   = w_xa[r_idx];
    assign w_add_y   = w_ya[r_idx];
    assign w_add_cin = (r_idx == '0) ? r_cin : r_carry;

    LadnerFischer32 u_adder (
        .x    (w_add_x),
        .y    (w_add_y),
        .cin  (w_add_cin),
        .s    (w_add_s),
        .cout (w_add_cout)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: accept -> NWORDS add passes -> hold until consumed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)  w_state_nxt = c_ST_ADD;
            c_ST_ADD:  if (w_last)    w_state_nxt = c_ST_HOLD;
            c_ST_HOLD: if (out_ready) w_state_nxt = c_ST_IDLE;
            default:                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Word index, inter-word carry and final carry-out; index stops at the
    // last word so no write can wrap back onto word 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_cin   <= cin;
        end else if (w_adding) begin
            r_carry <= w_add_cout;
            if (w_last) begin
                r_cout <= w_add_cout;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign cout = r_cout;

    // Per-word operand latches and sum registers
    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        logic [c_WORD_W-1:0] r_xw;
        logic [c_WORD_W-1:0] r_yw;
        logic [c_WORD_W-1:0] r_sw;

        // Capture operand word on acceptance; write sum when its pass runs
        always_ff @(posedge clk) begin
            if (rst) begin
                r_xw <= '0;
                r_yw <= '0;
                r_sw <= '0;
            end else begin
                if (w_accept) begin
                    r_xw <= x[k*c_WORD_W +: c_WORD_W];
                    r_yw <= y[k*c_WORD_W +: c_WORD_W];
                end
                if (w_adding && (r_idx == c_IDX_W'(k))) begin
                    r_sw <= w_add_s;
                end
            end
        end

        assign w_xa[k]                    = r_xw;
        assign w_ya[k]                    = r_yw;
        assign s[k*c_WORD_W +: c_WORD_W]  = r_sw;
    end

endmodule : multiword_add_seq
`default_nettype wire

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4, meaning the number of 32-bit words per operand (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand set offered.
REQ-005 SHALL have port in_ready, output, 1, block accepts an operand set this cycle.
REQ-006 SHALL have port x, input, 32*NWORDS, first addend, word 0 = bits [31:0].
REQ-007 SHALL have port y, input, 32*NWORDS, second addend.
REQ-008 SHALL have port cin, input, 1, carry into word 0.
REQ-009 SHALL have port out_valid, output, 1, result held valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port s, output, 32*NWORDS, registered sum.
REQ-012 SHALL have port cout, output, 1, registered carry out of the top word.

Function
REQ-013 SHALL compute {cout,s} = x + y + cin, modulo 2^(32*NWORDS+1), using exactly one LadnerFischer32 instance time-shared across words.
REQ-014 SHALL implement FSM states IDLE, ADD, HOLD; reset state IDLE.
REQ-015 SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready at a rising edge.
REQ-016 On acceptance SHALL latch x, y and cin, clear word index to 0, and enter ADD.
REQ-017 In ADD, word index k SHALL select operand words k; the adder carry-in SHALL be cin for k=0 and the carry register otherwise.
REQ-018 Each ADD edge SHALL write adder sum into s word k, store adder cout into the carry register, and increment k.
REQ-019 On the edge writing word NWORDS-1, SHALL load cout from adder cout and enter HOLD.
REQ-020 out_valid SHALL be 1 only in HOLD; it rises exactly NWORDS edges after the accepting edge.
REQ-021 In HOLD, s and cout SHALL remain stable until out_valid & out_ready; that edge SHALL return to IDLE.
REQ-022 in_valid and x/y/cin changes outside IDLE SHALL be ignored; latched operands SHALL not change mid-operation.
REQ-023 out_ready outside HOLD SHALL have no effect.
REQ-024 Throughput SHALL be one result per NWORDS+2 cycles minimum (accept, NWORDS adds, handshake, no overlap).
REQ-025 Word index SHALL never exceed NWORDS-1; no wrap-around writes after the last word.

Reset
REQ-026 rst SHALL force state IDLE, in_ready=1 (following the state), out_valid=0, s=0, cout=0, carry register=0, word index=0 on the next edge.
REQ-027 rst asserted during ADD or HOLD SHALL abort the operation; the partial result SHALL be discarded and never presented.
REQ-028 rst SHALL take priority over simultaneous in_valid or out_ready.

Structure
REQ-029 Shared package/header SHALL hold WORD_W=32 and the FSM state encodings; NWORDS stays a module parameter.
REQ-030 SHALL instantiate the existing LadnerFischer32 (x, y, cin, s, cout port order) as the sole sub-module; no new sub-module.
REQ-031 Operand storage SHALL be registers with a word-select mux; no combinational path from in_valid to out_valid.

Verification
REQ-032 NWORDS=4: x=all ones, y=0, cin=1 -> s=0, cout=1, out_valid 4 edges after accept.
REQ-033 x=0x00000000_00000000_00000000_FFFFFFFF, y=1, cin=0 -> s=0x00000000_00000000_00000001_00000000, cout=0 (cross-word carry).
REQ-034 x=y=0x42884743 repeated in all words, cin=0, then x=0xF28A47B3..., y=0x4B8B47A3... repeated, cin=1 -> match golden 129-bit model for both.
REQ-035 Hold out_ready=0 for 6 cycles in HOLD -> s, cout, out_valid stable, in_ready=0; in_valid pulses ignored.
REQ-036 Assert rst at word index 2 -> next cycle IDLE, out_valid=0, s=0; subsequent operation computes correctly.
REQ-037 1000 random operand sets with random in_valid/out_ready gaps -> all results equal golden model, none dropped or duplicated.
